// File: rtl/pdp8_mem_arb_if.sv
// PDP-8 memory arbiter bus bundle.
// CPU and DMA requester ports plus the 32Kx12 RAM side.
interface pdp8_mem_arb_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [11:0] cpu_wdata;
  logic        cpu_ack;
  logic [11:0] cpu_rdata;

  logic        dma_req;
  logic        dma_we;
  logic [14:0] dma_addr;
  logic [11:0] dma_wdata;
  logic        dma_ack;
  logic [11:0] dma_rdata;

  logic [14:0] ram_addr;
  logic [11:0] ram_data_in;
  logic [11:0] ram_data_out;
  logic        ram_rd;
  logic        ram_wr;

  logic        busy;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  ram_addr, ram_data_in,
    output ram_data_out,
    input  ram_rd, ram_wr,
    input  busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output ram_addr, ram_data_in,
    input  ram_data_out,
    output ram_rd, ram_wr,
    output busy
  );
endinterface

// File: rtl/pdp8_mem_arb.sv
// PDP-8 CPU / data-break memory arbiter.
// Alternating-priority grant, IDLE-SETUP-ACCESS-HOLD RAM cycle.
module pdp8_mem_arb #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  pdp8_mem_arb_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [3:0] CNT_LOAD =
    4'(ACCESS_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nx;
  logic [3:0]  r_cnt;

  logic        r_last;
  logic        r_win;
  logic        r_we;
  logic [14:0] r_addr;
  logic [11:0] r_wdata;

  logic [11:0] r_cpu_rdata;
  logic [11:0] r_dma_rdata;

  logic        r_rd;
  logic        r_wr;
  logic        r_cpu_ack;
  logic        r_dma_ack;
  logic        r_busy;

  logic        w_idle;
  logic        w_setup;
  logic        w_access;
  logic        w_hold;
  logic        w_any;
  logic        w_pick_dma;
  logic        w_grant;
  logic        w_done;

  assign w_idle   = (r_state == S_IDLE);
  assign w_setup  = (r_state == S_SETUP);
  assign w_access = (r_state == S_ACCESS);
  assign w_hold   = (r_state == S_HOLD);

  assign w_any = bus.cpu_req | bus.dma_req;

  // r_last: 0 = CPU granted last, 1 = DMA
  assign w_pick_dma = bus.dma_req
                    & (~bus.cpu_req | ~r_last);

  assign w_grant = w_idle & w_any;
  assign w_done  = w_access & (r_cnt == 4'd0);

  // Next-state decode
  always_comb begin
    w_state_nx = r_state;
    unique case (1'b1)
      w_idle: begin
        if (w_any) w_state_nx = S_SETUP;
      end
      w_setup: begin
        w_state_nx = S_ACCESS;
      end
      w_access: begin
        if (w_done) w_state_nx = S_HOLD;
      end
      w_hold: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Access wait counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 4'd0;
    end else if (w_setup) begin
      r_cnt <= CNT_LOAD;
    end else if (w_access && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Winner selection and request latch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last  <= 1'b0;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 15'd0;
      r_wdata <= 12'd0;
    end else if (w_grant) begin
      r_last <= w_pick_dma;
      r_win  <= w_pick_dma;
      if (w_pick_dma) begin
        r_we    <= bus.dma_we;
        r_addr  <= bus.dma_addr;
        r_wdata <= bus.dma_wdata;
      end else begin
        r_we    <= bus.cpu_we;
        r_addr  <= bus.cpu_addr;
        r_wdata <= bus.cpu_wdata;
      end
    end
  end

  // Read data capture on the last ACCESS edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_rdata <= 12'd0;
      r_dma_rdata <= 12'd0;
    end else if (w_done && !r_we) begin
      if (r_win) begin
        r_dma_rdata <= bus.ram_data_out;
      end else begin
        r_cpu_rdata <= bus.ram_data_out;
      end
    end
  end

  // Strobes, acks and busy registered off next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rd      <= (w_state_nx == S_ACCESS) & ~r_we;
      r_wr      <= (w_state_nx == S_ACCESS) & r_we;
      r_cpu_ack <= (w_state_nx == S_HOLD) & ~r_win;
      r_dma_ack <= (w_state_nx == S_HOLD) & r_win;
      r_busy    <= (w_state_nx != S_IDLE);
    end
  end

  assign bus.ram_addr    = r_addr;
  assign bus.ram_data_in = r_wdata;
  assign bus.ram_rd      = r_rd;
  assign bus.ram_wr      = r_wr;
  assign bus.cpu_ack     = r_cpu_ack;
  assign bus.dma_ack     = r_dma_ack;
  assign bus.cpu_rdata   = r_cpu_rdata;
  assign bus.dma_rdata   = r_dma_rdata;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_pdp8_mem_arb.sv
// Bench for pdp8_mem_arb: directed cases, random traffic
// against a transaction-level model, and access-width corners.
module tb_pdp8_mem_arb;

  localparam int AC = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pdp8_mem_arb_if b ();
  pdp8_mem_arb_if b1 ();
  pdp8_mem_arb_if b15 ();

  pdp8_mem_arb #(.ACCESS_CYCLES(AC)) dut (
    .clk(clk), .reset_n(rst_n), .bus(b));
  pdp8_mem_arb #(.ACCESS_CYCLES(1)) u1 (
    .clk(clk), .reset_n(rst_n), .bus(b1));
  pdp8_mem_arb #(.ACCESS_CYCLES(15)) u15 (
    .clk(clk), .reset_n(rst_n), .bus(b15));

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0o exp=%0o",
               tag, cyc, got, exp);
    end
  endtask

  // ---------------- environment RAM ----------------
  logic [11:0] ram [32768];
  bit          wrt [32768];

  function automatic logic [11:0] minit(input logic [14:0] a);
    if (a == 15'o12345) return 12'o4321;
    return 12'(a * 15'd7 + 15'd5);
  endfunction

  always @(posedge clk) begin
    if (b.ram_wr) begin
      ram[b.ram_addr] <= b.ram_data_in;
      wrt[b.ram_addr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    b.ram_data_out <= wrt[b.ram_addr] ? ram[b.ram_addr]
                                      : minit(b.ram_addr);
  end

  // ---------------- reference model ----------------
  logic [11:0] mm [32768];
  bit          mw [32768];

  bit          m_act;
  int          m_g;
  bit          m_win;
  bit          m_last;
  bit          m_we;
  logic [14:0] m_addr;
  logic [11:0] m_wd;
  logic [11:0] m_crd;
  logic [11:0] m_drd;

  function automatic logic [11:0] mrd(input logic [14:0] a);
    return mw[a] ? mm[a] : minit(a);
  endfunction

  task automatic m_reset();
    m_act  = 1'b0;
    m_last = 1'b0;
    m_addr = '0;
    m_wd   = '0;
    m_crd  = '0;
    m_drd  = '0;
  endtask

  // one transaction = grant edge g, done at g+AC+1, idle at g+AC+2
  task automatic m_edge();
    cyc++;
    if (m_act) begin
      if (cyc - m_g == AC + 1) begin
        if (m_we) begin
          mm[m_addr] = m_wd;
          mw[m_addr] = 1'b1;
        end else if (m_win) begin
          m_drd = mrd(m_addr);
        end else begin
          m_crd = mrd(m_addr);
        end
      end
      if (cyc - m_g == AC + 2) m_act = 1'b0;
    end else if (b.cpu_req || b.dma_req) begin
      m_win  = (b.cpu_req && b.dma_req) ? !m_last : b.dma_req;
      m_last = m_win;
      m_act  = 1'b1;
      m_g    = cyc;
      m_we   = m_win ? b.dma_we : b.cpu_we;
      m_addr = m_win ? b.dma_addr : b.cpu_addr;
      m_wd   = m_win ? b.dma_wdata : b.cpu_wdata;
    end
  endtask

  task automatic check_all();
    int off;
    off = cyc - m_g;
    chk("busy", b.busy, m_act);
    chk("ram_rd", b.ram_rd,
        m_act && off >= 1 && off <= AC && !m_we);
    chk("ram_wr", b.ram_wr,
        m_act && off >= 1 && off <= AC && m_we);
    chk("cpu_ack", b.cpu_ack,
        m_act && off == AC + 1 && !m_win);
    chk("dma_ack", b.dma_ack,
        m_act && off == AC + 1 && m_win);
    chk("cpu_rdata", b.cpu_rdata, m_crd);
    chk("dma_rdata", b.dma_rdata, m_drd);
    chk("ram_addr", b.ram_addr, m_addr);
    chk("ram_data_in", b.ram_data_in, m_wd);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drv(input bit p, input bit rq, input bit we,
                     input logic [14:0] a, input logic [11:0] d);
    if (p) begin
      b.dma_req = rq; b.dma_we = we;
      b.dma_addr = a; b.dma_wdata = d;
    end else begin
      b.cpu_req = rq; b.cpu_we = we;
      b.cpu_addr = a; b.cpu_wdata = d;
    end
  endtask

  function automatic logic [14:0] raddr();
    if ($urandom_range(0, 3) == 0) return 15'($urandom);
    return 15'($urandom_range(0, 15));
  endfunction

  // single transaction on the main DUT, other port idle
  task automatic one_txn(input bit p, input bit we,
                         input logic [14:0] a,
                         input logic [11:0] d,
                         output int nstr, output int lat,
                         output int nack);
    int e;
    int ackc;
    bit ak;
    ackc = -1; nstr = 0; nack = 0; lat = -1;
    drv(p, 1'b1, we, a, d);
    e = cyc + 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (b.ram_rd || b.ram_wr) nstr++;
      if (b.busy) begin
        chk("hold_addr", b.ram_addr, a);
        if (we) chk("hold_wdata", b.ram_data_in, d);
      end
      ak = p ? b.dma_ack : b.cpu_ack;
      if (ak) begin
        nack++;
        if (ackc < 0) begin
          ackc = cyc;
          drv(p, 1'b0, we, a, d);
        end
      end
      if (ackc >= 0 && cyc >= ackc + 2) break;
    end
    if (ackc < 0) chk("txn_timeout", 0, 1);
    else lat = ackc + 1 - e;
  endtask

  task automatic rnd_port(input bit p);
    bit rq;
    bit mine;
    int off;
    rq   = p ? b.dma_req : b.cpu_req;
    off  = cyc - m_g;
    mine = m_act && (m_win == p);
    if (rq && mine && off == AC + 1) begin
      drv(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          raddr(), 12'($urandom));
    end else if (rq && mine && off <= AC &&
                 $urandom_range(0, 7) == 0) begin
      drv(p, 1'b0, 1'($urandom_range(0, 1)),
          raddr(), 12'($urandom));
    end else if (!rq && $urandom_range(0, 2) == 0) begin
      drv(p, 1'b1, 1'($urandom_range(0, 1)),
          raddr(), 12'($urandom));
    end
  endtask

  // read on a corner-width instance, checked with constants
  task automatic aux_run(input bit big, input int exp_w,
                         input int exp_lat,
                         input logic [11:0] exp_d);
    int e;
    int nrd;
    int nack;
    int ackc;
    bit rd;
    bit ak;
    nrd = 0; nack = 0; ackc = -1;
    if (big) begin
      b15.cpu_req = 1'b1; b15.cpu_we = 1'b0;
      b15.cpu_addr = 15'o777;
    end else begin
      b1.cpu_req = 1'b1; b1.cpu_we = 1'b0;
      b1.cpu_addr = 15'o777;
    end
    e = cyc + 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      rd = big ? b15.ram_rd : b1.ram_rd;
      ak = big ? b15.cpu_ack : b1.cpu_ack;
      if (rd) nrd++;
      if (ak) begin
        nack++;
        if (ackc < 0) begin
          ackc = cyc;
          if (big) b15.cpu_req = 1'b0;
          else b1.cpu_req = 1'b0;
        end
      end
      if (ackc >= 0 && cyc >= ackc + 3) break;
    end
    if (ackc < 0) begin
      chk("aux_timeout", 0, 1);
    end else begin
      chk("aux_rd_width", nrd, exp_w);
      chk("aux_latency", ackc + 1 - e, exp_lat);
      chk("aux_nack", nack, 1);
      chk("aux_rdata", big ? b15.cpu_rdata : b1.cpu_rdata, exp_d);
    end
  endtask

  task automatic aux_idle(input bit big);
    if (big) begin
      b15.cpu_req = 0; b15.cpu_we = 0;
      b15.cpu_addr = 0; b15.cpu_wdata = 0;
      b15.dma_req = 0; b15.dma_we = 0;
      b15.dma_addr = 0; b15.dma_wdata = 0;
      b15.ram_data_out = 12'o5670;
    end else begin
      b1.cpu_req = 0; b1.cpu_we = 0;
      b1.cpu_addr = 0; b1.cpu_wdata = 0;
      b1.dma_req = 0; b1.dma_we = 0;
      b1.dma_addr = 0; b1.dma_wdata = 0;
      b1.ram_data_out = 12'o1234;
    end
  endtask

  initial begin
    int nstr;
    int lat;
    int nack;
    int nrst;
    bit who_q[$];
    int cyc_q[$];

    rst_n = 1'b0;
    drv(0, 0, 0, '0, '0);
    drv(1, 0, 0, '0, '0);
    aux_idle(0);
    aux_idle(1);
    m_reset();
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // CPU read of a preset word
    one_txn(0, 0, 15'o12345, 12'o0, nstr, lat, nack);
    chk("rd_strobe_width", nstr, 2);
    chk("rd_latency", lat, 4);
    chk("rd_nack", nack, 1);
    chk("rd_data", b.cpu_rdata, 12'o4321);

    // DMA write then CPU read-back
    one_txn(1, 1, 15'o00017, 12'o7777, nstr, lat, nack);
    chk("wr_strobe_width", nstr, 2);
    chk("wr_nack", nack, 1);
    one_txn(0, 0, 15'o00017, 12'o0, nstr, lat, nack);
    chk("readback", b.cpu_rdata, 12'o7777);

    // tie after reset: DMA, CPU, DMA, CPU every 5 cycles
    pulse_rst();
    drv(0, 1, 0, 15'o00100, 12'o0);
    drv(1, 1, 0, 15'o00200, 12'o0);
    for (int i = 0; i < 80 && who_q.size() < 4; i++) begin
      tick();
      if (b.cpu_ack) begin who_q.push_back(0); cyc_q.push_back(cyc); end
      if (b.dma_ack) begin who_q.push_back(1); cyc_q.push_back(cyc); end
    end
    drv(0, 0, 0, '0, '0);
    drv(1, 0, 0, '0, '0);
    if (who_q.size() < 4) begin
      chk("tie_timeout", who_q.size(), 4);
    end else begin
      for (int i = 0; i < 4; i++)
        chk("tie_order", who_q[i], (i % 2 == 0) ? 1 : 0);
      for (int i = 1; i < 4; i++)
        chk("tie_spacing", cyc_q[i] - cyc_q[i-1], 5);
    end
    repeat (3) tick();

    // request changed and dropped during SETUP
    drv(0, 1, 1, 15'o00123, 12'o5252);
    tick();
    chk("setup_busy", b.busy, 1);
    drv(0, 0, 1, 15'o00456, 12'o0000);
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b.cpu_ack) nack++;
    end
    chk("drop_nack", nack, 1);
    chk("drop_wr_data", ram[15'o00123], 12'o5252);
    chk("drop_no_wr", wrt[15'o00456], 0);

    // random traffic, occasional reset during a write access
    nrst = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (m_act && m_we && cyc - m_g == 1 && nrst < 4 &&
          $urandom_range(0, 5) == 0) begin
        pulse_rst();
        chk("rst_wr_drop", b.ram_wr, 0);
        nrst++;
      end
      rnd_port(0);
      rnd_port(1);
    end
    drv(0, 0, 0, '0, '0);
    drv(1, 0, 0, '0, '0);
    repeat (8) tick();

    // access-width corners
    aux_run(0, 1, 3, 12'o1234);
    aux_run(1, 15, 17, 12'o5670);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
